// File: rtl/fetch_pkg.sv
// Shared types, defaults and protocol-check macro for the instruction fetch front end.
`ifndef FQ_ASSERT
`define FQ_ASSERT(lbl, prop) lbl: assert property (@(posedge clk) disable iff (!rst) prop);
`endif

package fetch_pkg;
  localparam int          FQ_DEPTH    = 4;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential word address; wraps naturally at 32 bits.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_queue_chk.sv
// Protocol and invariant checks for fetch_queue.
module fetch_queue_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          redirect_valid,
  input logic          imem_req_valid,
  input logic          imem_req_ready,
  input logic [31:0]   imem_req_addr,
  input logic          imem_rsp_valid,
  input logic          rsp_fire,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] pcf_count,
  input logic          pcf_empty,
  input logic          pcf_full,
  input logic          q_full,
  input logic          rsp_keep,
  input logic          inst_fire
);
  `FQ_ASSERT(a_rsp_has_credit, imem_rsp_valid |-> (outstanding != '0))
  `FQ_ASSERT(a_pcf_tracks, pcf_count == outstanding)
  `FQ_ASSERT(a_pcf_head, rsp_fire |-> !pcf_empty)
  `FQ_ASSERT(a_pcf_no_ovf, !(imem_req_valid && imem_req_ready && pcf_full))
  `FQ_ASSERT(a_q_no_ovf, !(rsp_keep && q_full && !inst_fire))
  `FQ_ASSERT(a_req_stable, (imem_req_valid && !imem_req_ready) |=> (redirect_valid || (imem_req_valid && $stable(imem_req_addr))))
endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: owns the fetch PC, tracks in-flight memory requests and
// buffers returned words with their PCs for the decode side.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] q_count, pcf_count;
  logic [CW:0]   credit_used;
  logic          q_empty, q_full, pcf_empty, pcf_full;
  logic          req_fire, rsp_fire, rsp_keep, inst_fire;
  logic [31:0]   pcf_head;
  fetch_entry_t  q_head, q_push_entry;

  // Buffered words plus in-flight requests may never exceed DEPTH, so the queue cannot overflow.
  assign credit_used    = {1'b0, q_count} + {1'b0, outstanding_q};
  assign imem_req_valid = rst && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep       = rsp_fire && (drop_cnt_q == '0) && !redirect_valid;

  assign q_push_entry.pc   = pcf_head;
  assign q_push_entry.inst = imem_rsp_data;

  assign inst_valid    = !q_empty && !redirect_valid;
  assign inst_fire     = inst_valid && inst_ready;
  assign inst_data     = q_empty ? 32'h0000_0000 : q_head.inst;
  assign inst_pc       = q_empty ? 32'h0000_0000 : q_head.pc;
  assign inst_pc_plus4 = pc_next(inst_pc);

  // Fetch PC and request bookkeeping; a redirect turns every in-flight request stale.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_cnt_d = outstanding_q - CW'(rsp_fire);
    end else begin
      fetch_pc_d = req_fire ? pc_next(fetch_pc_q) : fetch_pc_q;
      if (rsp_fire && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (q_push_entry),
    .pop       (inst_fire),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  // Request PCs are never flushed: stale entries drain as their responses return.
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_fire),
    .head_data (pcf_head),
    .count     (pcf_count),
    .empty     (pcf_empty),
    .full      (pcf_full)
  );

  fetch_queue_chk #(.CW(CW)) u_chk (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .rsp_fire       (rsp_fire),
    .outstanding    (outstanding_q),
    .pcf_count      (pcf_count),
    .pcf_empty      (pcf_empty),
    .pcf_full       (pcf_full),
    .q_full         (q_full),
    .rsp_keep       (rsp_keep),
    .inst_fire      (inst_fire)
  );
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupled instruction-fetch front end feeding the MIPS datapath's instruction and PC inputs. It owns the fetch PC, issues in-order requests to a variable-latency instruction memory over a valid/ready channel, and buffers returned words with their PCs in a small queue. The queue hands instructions to the decode/execute side on a second valid/ready channel. A redirect input (taken branch, `j`, `jal`, `jr`) flushes everything younger and restarts fetch at a new PC.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; also the maximum number of outstanding memory requests; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; deassertion is synchronised externally.
- `redirect_valid`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address, word-aligned.
- `imem_req_valid`  out  1  request pending.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response word valid; responses are in request order, at least 1 cycle after acceptance; no backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  consumer takes the head.
- `inst_data`  out  32  instruction.
- `inst_pc`  out  32  address of `inst_data`.
- `inst_pc_plus4`  out  32  `inst_pc + 4`; used for link-register writes and branch-target adds.

## Operation
- State:
  - `fetch_pc`.
  - Queue count (0..DEPTH).
  - `outstanding` (0..DEPTH, accepted requests not yet responded).
  - `drop_cnt` (0..DEPTH, stale responses still to discard).
  - Per-outstanding-request PC FIFO (DEPTH deep), so each returned word is paired with its address.
- Issue rule: `imem_req_valid` = !`redirect_valid` && (count + `outstanding` < DEPTH).
  - On a request handshake: `fetch_pc` += 4, with 32-bit wrap from 0xFFFF_FFFC to 0.
  - The request PC is pushed to the PC FIFO.
- Response, `drop_cnt` == 0: push {PC-FIFO head, `imem_rsp_data`} into the queue and pop the PC FIFO.
- Response, `drop_cnt` > 0: discard the word, pop the PC FIFO, `drop_cnt` -= 1.
- `outstanding` update:
  - +1 on a request handshake.
  - −1 on every response, whether kept or dropped.
- Consume: when `inst_valid` && `inst_ready`, pop the queue head.
- Redirect cycle (`redirect_valid`=1) has priority over all other events:
  - Queue is cleared; any pop that cycle is void.
  - `fetch_pc` ← `redirect_pc`.
  - `drop_cnt` ← `outstanding` − (`imem_rsp_valid` ? 1 : 0) + current `drop_cnt` contribution already included in `outstanding`; i.e. every in-flight request becomes stale.
  - A response arriving in the redirect cycle is discarded.
- After a redirect, new requests may issue while `drop_cnt` > 0. Stale responses still count against the DEPTH credit until they return.
- Back-to-back redirects: the last one wins; the `drop_cnt` reload covers all requests in flight.
- Response with `outstanding` == 0 is a protocol violation: ignored, no state change (simulation assertion).
- Simultaneous push and pop at any count is legal. The credit rule guarantees the queue never overflows.

## Timing
- Reset values while `rst`=0:
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `inst_pc_plus4`=4.
  - All counters 0.
- First cycle after `rst` rises: `imem_req_valid`=1, `imem_req_addr`=`RESET_PC`.
- Response to `inst_valid`: 1 cycle; a word received at edge N is visible at the head after edge N. There is no combinational path from `imem_rsp_*` to `inst_*`.
- `inst_valid` is combinationally masked low while `redirect_valid`=1, so a consumer never sees a handshake in a redirect cycle.
- `redirect_valid` is held 1 cycle by the producer. The first request to `redirect_pc` appears the following cycle.
- Steady-state throughput is one instruction per cycle with single-cycle memory and `inst_ready` held 1.
- `imem_req_valid` and `imem_req_addr` stay stable until accepted, unless a redirect intervenes.

## Structure
- Package `fetch_pkg`:
  - `localparam` defaults for DEPTH and RESET_PC.
  - `typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_entry_t`.
  - Assertion macros for the protocol checks.
- One sub-module, `sync_fifo` (parameterised width/depth, synchronous flush, count output). It is instantiated twice:
  - `fetch_entry_t` queue: flushed on redirect.
  - 32-bit request-PC FIFO: never flushed; stale entries drain via `drop_cnt`.

## Test plan
- Reset release, memory latency 1, `inst_ready`=1 → requests at 0x0, 0x4, 0x8… on consecutive cycles; `inst_pc` 0x0 at cycle 3 after release, then +4 every cycle.
- `inst_ready`=0, latency 1 → exactly 4 requests (0x0–0xC); `imem_req_valid` stays 0; `inst_valid`=1 with `inst_pc`=0x0 held.
- Latency 3, 3 outstanding, redirect to 0x400 → 3 responses discarded; next `inst_pc`=0x400 with its matching data; `inst_pc_plus4`=0x404.
- Redirect in the same cycle as a response and a consumer handshake → response dropped, no instruction consumed, queue empty the next cycle.
- `redirect_pc`=0xFFFF_FFFC → requests 0xFFFF_FFFC then 0x0000_0000.
- Async reset asserted mid-stream with 2 outstanding → all outputs at reset values immediately; late responses after release are ignored (assertion fires), fetch restarts at `RESET_PC`.
